state_ram_sched: RTL

Read-modify-write scheduler for the slice's 16-word x 24-bit state RAM (lattice_ram_24bit_16word, registered read, 1-cycle latency). It arbitrates between the slice update requester (add/sub delta) and a host port (read/write), drives the RAM read/write ports, and forwards results across back-to-back same-address operations. After reset it sweeps the RAM to zero before accepting requests.

---
 rtl/state_ram_pkg.sv | 20 ++
 rtl/state_ram_sched_if.sv | 34 +++
 rtl/state_ram_arb.sv | 43 ++++
 rtl/state_ram_sched.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/state_ram_pkg.sv
// Shared constants and enums for the state RAM read-modify-write scheduler.
// Contents: DATA_W/ADR_W/DEPTH, FSM state enum, pipeline op-type enum.
package state_ram_pkg;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned ADR_W  = 4;
  localparam int unsigned DEPTH  = 2 ** ADR_W;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } fsm_e;

  typedef enum logic [1:0] {
    OpUpd,
    OpHrd,
    OpHwr
  } op_e;

endpackage

// File: rtl/state_ram_sched_if.sv
// Request-side bus of the state RAM scheduler: update requester and host port.
// master: requester side (drives req/operands, sees acks and read data).
// slave:  scheduler side.
interface state_ram_sched_if;
  import state_ram_pkg::*;

  logic              upd_req;
  logic [ADR_W-1:0]  upd_adr;
  logic [DATA_W-1:0] upd_delta;
  logic              upd_sub;
  logic              upd_ack;
  logic              host_req;
  logic              host_wr;
  logic [ADR_W-1:0]  host_adr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  modport master (
    output upd_req, upd_adr, upd_delta, upd_sub,
    input  upd_ack,
    output host_req, host_wr, host_adr, host_wdata,
    input  host_ack, host_rvalid, host_rdata
  );

  modport slave (
    input  upd_req, upd_adr, upd_delta, upd_sub,
    output upd_ack,
    input  host_req, host_wr, host_adr, host_wdata,
    output host_ack, host_rvalid, host_rdata
  );

endinterface

// File: rtl/state_ram_arb.sv
// Grant logic between the update requester and the host port.
// Update has priority; after HOST_STARVE consecutive update grants with the
// host waiting, the host is forced through.
// Ports: clk, rst (async, active high), run (grants enabled), upd_req,
//        host_req, upd_gnt, host_gnt (combinational, mutually exclusive).
module state_ram_arb #(
  parameter int unsigned HOST_STARVE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic upd_req,
  input  logic host_req,
  output logic upd_gnt,
  output logic host_gnt
);

  localparam int unsigned CntW = (HOST_STARVE > 0) ? $clog2(HOST_STARVE + 1) : 1;

  logic [CntW-1:0] starve_q, starve_d;
  logic            force_host;

  always_comb begin
    force_host = host_req && (starve_q == CntW'(HOST_STARVE));
    host_gnt   = run && host_req && (!upd_req || force_host);
    upd_gnt    = run && upd_req && !force_host;
    starve_d   = starve_q;
    if (!host_req || host_gnt) begin
      starve_d = '0;
    end else if (upd_gnt) begin
      starve_d = starve_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/state_ram_sched.sv
// Read-modify-write scheduler for the 16 x 24-bit state RAM (registered read,
// 1-cycle latency). Zero-sweeps the RAM after reset, then runs a two-stage
// pipeline: G (grant, RAM read issued) and S1 (operand + result, RAM write).
// Ports: clock_200, reset (async, active high), bus (update/host requests),
//        ovf (carry/borrow pulse in S1), init_busy, state_* (RAM ports),
//        state_value (RAM Q), ram_reset (RAM reset, follows reset).
module state_ram_sched
  import state_ram_pkg::*;
#(
  parameter int unsigned SATURATE    = 0,
  parameter int unsigned HOST_STARVE = 4
) (
  input  logic              clock_200,
  input  logic              reset,
  state_ram_sched_if.slave  bus,
  output logic              ovf,
  output logic              init_busy,
  output logic [ADR_W-1:0]  state_read_adr,
  output logic              state_read_en,
  output logic [ADR_W-1:0]  state_write_adr,
  output logic              state_write_en,
  output logic [DATA_W-1:0] state_write_data,
  input  logic [DATA_W-1:0] state_value,
  output logic              ram_reset
);

  fsm_e              state_q, state_d;
  logic [ADR_W-1:0]  cnt_q, cnt_d;
  logic              run, upd_gnt, host_gnt;

  op_e               g_op;
  logic [ADR_W-1:0]  g_adr;
  logic [DATA_W-1:0] g_data;

  logic              s1_valid_q, s1_sub_q;
  op_e               s1_op_q;
  logic [ADR_W-1:0]  s1_adr_q;
  logic [DATA_W-1:0] s1_data_q;

  // Result of the op that left S1 last cycle; the RAM read issued alongside it
  // returned the pre-write value.
  logic              fwd_valid_q;
  logic [ADR_W-1:0]  fwd_adr_q;
  logic [DATA_W-1:0] fwd_data_q;

  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  logic [DATA_W-1:0] operand, result;
  logic [DATA_W:0]   sum;
  logic              carry;

  assign run = (state_q == StRun);

  state_ram_arb #(
    .HOST_STARVE(HOST_STARVE)
  ) u_arb (
    .clk      (clock_200),
    .rst      (reset),
    .run      (run),
    .upd_req  (bus.upd_req),
    .host_req (bus.host_req),
    .upd_gnt  (upd_gnt),
    .host_gnt (host_gnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StInit) begin
      cnt_d = cnt_q + ADR_W'(1);
      if (cnt_q == '1) begin
        state_d = StRun;
      end
    end
  end

  // Stage G
  always_comb begin
    g_op   = OpUpd;
    g_adr  = '0;
    g_data = '0;
    if (upd_gnt) begin
      g_adr  = bus.upd_adr;
      g_data = bus.upd_delta;
    end else if (host_gnt) begin
      g_op   = bus.host_wr ? OpHwr : OpHrd;
      g_adr  = bus.host_adr;
      g_data = bus.host_wdata;
    end
  end

  assign state_read_en  = upd_gnt || host_gnt;
  assign state_read_adr = g_adr;

  // Stage S1
  always_comb begin
    operand = (fwd_valid_q && (fwd_adr_q == s1_adr_q)) ? fwd_data_q : state_value;
    if (s1_sub_q) begin
      sum = {1'b0, operand} - {1'b0, s1_data_q};
    end else begin
      sum = {1'b0, operand} + {1'b0, s1_data_q};
    end
    carry  = sum[DATA_W];
    result = sum[DATA_W-1:0];
    if (s1_op_q == OpHwr) begin
      result = s1_data_q;
    end else if ((SATURATE != 0) && carry) begin
      result = s1_sub_q ? '0 : '1;
    end
    ovf = s1_valid_q && (s1_op_q == OpUpd) && carry;
  end

  // Writes are gated by reset so nothing commits while it is asserted.
  always_comb begin
    state_write_en   = 1'b0;
    state_write_adr  = '0;
    state_write_data = '0;
    if (!reset) begin
      if (state_q == StInit) begin
        state_write_en  = 1'b1;
        state_write_adr = cnt_q;
      end else if (s1_valid_q && (s1_op_q != OpHrd)) begin
        state_write_en   = 1'b1;
        state_write_adr  = s1_adr_q;
        state_write_data = result;
      end
    end
  end

  always_ff @(posedge clock_200 or posedge reset) begin
    if (reset) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OpUpd;
      s1_sub_q    <= 1'b0;
      s1_adr_q    <= '0;
      s1_data_q   <= '0;
      fwd_valid_q <= 1'b0;
      fwd_adr_q   <= '0;
      fwd_data_q  <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= upd_gnt || host_gnt;
      s1_op_q     <= g_op;
      s1_sub_q    <= upd_gnt && bus.upd_sub;
      s1_adr_q    <= g_adr;
      s1_data_q   <= g_data;
      fwd_valid_q <= s1_valid_q && (s1_op_q != OpHrd);
      fwd_adr_q   <= s1_adr_q;
      fwd_data_q  <= result;
      rvalid_q    <= s1_valid_q && (s1_op_q == OpHrd);
      if (s1_valid_q && (s1_op_q == OpHrd)) begin
        rdata_q <= operand;
      end
    end
  end

  assign bus.upd_ack     = upd_gnt;
  assign bus.host_ack    = host_gnt;
  assign bus.host_rvalid = rvalid_q;
  assign bus.host_rdata  = rdata_q;
  assign init_busy       = (state_q == StInit);
  assign ram_reset       = reset;

endmodule
